// File: rtl/spiral_plotter.sv
// spiral_plotter: walks a rectangular spiral over the frame, one pixel
// write per DRAW cycle, with a pausable inter-pixel wait.
module spiral_plotter #(
  parameter int X_W         = 8,
  parameter int Y_W         = 7,
  parameter int X_MAX       = 159,
  parameter int Y_MAX       = 119,
  parameter int COLOR_W     = 9,
  parameter int DELAY_TICKS = 88607,
  parameter int CNT_W       = 22
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               abort,
  input  logic               pause,
  input  logic [1:0]         mode,
  input  logic [COLOR_W-1:0] fixed_color,
  output logic [X_W-1:0]     x,
  output logic [Y_W-1:0]     y,
  output logic [COLOR_W-1:0] color,
  output logic               writeEn,
  output logic               busy,
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_DRAW, S_WAIT, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    LEG_D, LEG_R, LEG_U, LEG_L
  } leg_t;

  localparam int LAST_I = (DELAY_TICKS == 0) ? 0 : DELAY_TICKS - 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_I);

  state_t             state;
  leg_t               leg;
  leg_t               nleg;
  leg_t               mv;
  logic [X_W-1:0]     l, r, x_nx;
  logic [Y_W-1:0]     t, b, y_nx;
  logic [CNT_W-1:0]   cnt;
  logic               ccw_q;
  logic               fix_q;
  logic [COLOR_W-1:0] fcol_q;
  logic               last;
  logic               empty;
  logic [8:0]         pat;

  always_comb begin
    last  = 1'b0;
    nleg  = leg;
    unique case (leg)
      LEG_D: begin
        last = (y == b);
        nleg = ccw_q ? LEG_L : LEG_R;
      end
      LEG_R: begin
        last = (x == r);
        nleg = ccw_q ? LEG_D : LEG_U;
      end
      LEG_U: begin
        last = (y == t);
        nleg = ccw_q ? LEG_R : LEG_L;
      end
      LEG_L: begin
        last = (x == l);
        nleg = ccw_q ? LEG_U : LEG_D;
      end
    endcase
    // vertical legs shrink a column bound, horizontal legs a row bound
    empty = (leg == LEG_D || leg == LEG_U) ? (l == r) : (t == b);
    mv    = last ? nleg : leg;
    x_nx  = x;
    y_nx  = y;
    unique case (mv)
      LEG_D: y_nx = y + 1'b1;
      LEG_R: x_nx = x + 1'b1;
      LEG_U: y_nx = y - 1'b1;
      LEG_L: x_nx = x - 1'b1;
    endcase
  end

  assign pat = {x[4:2] ^ y[4:2], x[3:1] ^ y[3:1], x[2:0] ^ y[2:0]};
  assign color = fix_q ? fcol_q : COLOR_W'(pat);

  assign writeEn = (state == S_DRAW);
  assign done    = (state == S_DONE);
  assign busy    = (state == S_INIT) || (state == S_DRAW)
                || (state == S_WAIT);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      leg    <= LEG_D;
      x      <= '0;
      y      <= '0;
      l      <= '0;
      r      <= '0;
      t      <= '0;
      b      <= '0;
      cnt    <= '0;
      ccw_q  <= 1'b0;
      fix_q  <= 1'b0;
      fcol_q <= '0;
    end else if (abort && state != S_IDLE) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start && !abort) begin
            ccw_q  <= mode[0];
            fix_q  <= mode[1];
            fcol_q <= fixed_color;
            state  <= S_INIT;
          end
        end
        S_INIT: begin
          x     <= '0;
          y     <= '0;
          l     <= '0;
          r     <= X_W'(X_MAX);
          t     <= '0;
          b     <= Y_W'(Y_MAX);
          leg   <= ccw_q ? LEG_R : LEG_D;
          state <= S_DRAW;
        end
        S_DRAW: begin
          cnt <= '0;
          if (last && empty) begin
            state <= S_DONE;
          end else begin
            if (last) begin
              leg <= nleg;
              unique case (leg)
                LEG_D: if (ccw_q) r <= r - 1'b1;
                       else       l <= l + 1'b1;
                LEG_R: if (ccw_q) t <= t + 1'b1;
                       else       b <= b - 1'b1;
                LEG_U: if (ccw_q) l <= l + 1'b1;
                       else       r <= r - 1'b1;
                LEG_L: if (ccw_q) b <= b - 1'b1;
                       else       t <= t + 1'b1;
              endcase
            end
            x     <= x_nx;
            y     <= y_nx;
            state <= (DELAY_TICKS == 0) ? S_DRAW : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!pause) begin
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              state <= S_DRAW;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/spiral_plotter.md
SPIRAL_PLOTTER -- requirements
Module: spiral_plotter

Interface
REQ-001 SHALL have parameter X_W, default 8: x coordinate width, at least 5.
REQ-002 SHALL have parameter Y_W, default 7: y coordinate width, at least 5.
REQ-003 SHALL have parameter X_MAX, default 159: rightmost column, less than 2^X_W.
REQ-004 SHALL have parameter Y_MAX, default 119: bottom row, less than 2^Y_W.
REQ-005 SHALL have parameter COLOR_W, default 9: pixel colour width.
REQ-006 SHALL have parameter DELAY_TICKS, default 88607: wait cycles between pixels, 0 allowed.
REQ-007 SHALL have parameter CNT_W, default 22: delay counter width, 2^CNT_W > DELAY_TICKS.
REQ-008 SHALL have port clk, input, 1: clock; all logic on the rising edge.
REQ-009 SHALL have port resetn, input, 1: reset, asynchronous, active-low.
REQ-010 SHALL have port start, input, 1: level-sampled request to begin a spiral.
REQ-011 SHALL have port abort, input, 1: synchronous cancel of the current spiral.
REQ-012 SHALL have port pause, input, 1: freezes the inter-pixel wait.
REQ-013 SHALL have port mode, input, 2: bit0 selects orientation (0 CW, 1 CCW); bit1 selects colour (0 XOR pattern, 1 fixed).
REQ-014 SHALL have port fixed_color, input, COLOR_W: colour used when mode[1]=1.
REQ-015 SHALL have port x, output, X_W: pixel column.
REQ-016 SHALL have port y, output, Y_W: pixel row.
REQ-017 SHALL have port color, output, COLOR_W: pixel colour.
REQ-018 SHALL have port writeEn, output, 1: pixel write strobe.
REQ-019 SHALL have port busy, output, 1: high from INIT through the last pixel.
REQ-020 SHALL have port done, output, 1: one-cycle pulse on normal completion.

Function
REQ-021 SHALL implement states IDLE, INIT, DRAW, WAIT and DONE.
REQ-022 SHALL transition IDLE->INIT when start=1, latching mode and fixed_color.
REQ-023 SHALL, in INIT, set x=0, y=0, bounds L=0, R=X_MAX, T=0, B=Y_MAX and the first leg (CW: down; CCW: right), then go to DRAW.
REQ-024 SHALL, in DRAW, assert writeEn for exactly one cycle with the current x, y and color, then advance x/y on the same clock edge.
REQ-025 SHALL use leg order down->right->up->left for CW.
REQ-026 SHALL, for CW, on the last pixel of a leg (down: y==B; right: x==R; up: y==T; left: x==L) apply L+1, B-1, R-1 or T+1 respectively.
REQ-027 SHALL use leg order right->down->left->up for CCW, applying T+1, R-1, B-1 or L+1 respectively on each leg's last pixel.
REQ-028 SHALL, when a bound update leaves the region empty (L>R or T>B), go to DONE; otherwise it SHALL step one pixel in the new leg direction, without writing that move, and go to WAIT.
REQ-029 SHALL, in the non-final case, step one pixel along the current leg and go to WAIT.
REQ-030 SHALL write every pixel of the (X_MAX+1)x(Y_MAX+1) rectangle exactly once per spiral.
REQ-031 SHALL, in WAIT, count DELAY_TICKS enabled cycles and then return to DRAW, so writeEn pulses are DELAY_TICKS+1 cycles apart.
REQ-032 SHALL skip WAIT when DELAY_TICKS=0, writing one pixel per cycle.
REQ-033 SHALL hold the WAIT counter while pause=1.
REQ-034 SHALL ignore pause in DRAW.
REQ-035 SHALL compute the mode[1]=0 colour as {x[4:2]^y[4:2], x[3:1]^y[3:1], x[2:0]^y[2:0]}, truncated or zero-extended on the MSB side to COLOR_W.
REQ-036 SHALL output the latched fixed_color when mode[1]=1.
REQ-037 SHALL pulse done for one cycle in DONE, then go to IDLE; x and y SHALL hold their last values.
REQ-038 SHALL ignore start while busy.
REQ-039 SHALL, when abort=1 in any non-IDLE state, force IDLE on the next edge with no writeEn and no done; abort SHALL take priority over start.
REQ-040 SHALL keep writeEn=0 outside DRAW and SHALL perform all bound arithmetic at coordinate width without wrap-around.

Reset
REQ-041 SHALL, while resetn=0 at any time including mid-spiral, force state IDLE, x=0, y=0, writeEn=0, busy=0, done=0, delay counter 0 and latched mode/fixed_color 0.
REQ-042 SHALL therefore output color=0 during reset.

Verification
REQ-043 SHALL check CW with X_MAX=3, Y_MAX=2, DELAY_TICKS=0: writes are (0,0)(0,1)(0,2)(1,2)(2,2)(3,2)(3,1)(3,0)(2,0)(1,0)(1,1)(2,1) on consecutive cycles, then one done pulse.
REQ-044 SHALL check CCW with the same parameters: writes are (0,0)(1,0)(2,0)(3,0)(3,1)(3,2)(2,2)(1,2)(0,2)(0,1)(1,1)(2,1), then done.
REQ-045 SHALL check DELAY_TICKS=3 with pause held 5 cycles during WAIT: writeEn pulses are 4 cycles apart, and 9 apart across the pause.
REQ-046 SHALL check default parameters: exactly 19200 writeEn pulses, each (x,y) written once, color matching REQ-035.
REQ-047 SHALL check abort after the 5th pixel: IDLE next cycle, no done; a new start restarts at (0,0).
REQ-048 SHALL check resetn low mid-spiral: outputs go to the reset values immediately, and start during busy has no effect.
